// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a registered carry,
// start/busy/done handshake, result committed atomically on the final digit.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] r_cat;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        c_d     = c_q;
        count_d = count_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        dsum  = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
        // Concatenating then taking the upper WIDTH bits shifts the new digit in
        // from the top, and also covers DIGIT == WIDTH without a special case.
        r_cat = {dsum[DIGIT-1:0], r_sh_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    c_d     = cin ^ sub;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_sh_d  = r_cat[WIDTH+DIGIT-1:DIGIT];
                c_d     = dsum[DIGIT];
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    s_d     = r_cat[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = dsum[DIGIT];
                    // carry into the MSB is recovered as a^b^sum at the top bit
                    ovf_d   = a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
                    count_d = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            count_q <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            c_q     <= c_d;
            count_q <= count_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
